// File: rtl/lcd_pkg.sv
// Shared types, init ROM and default timing for the HD44780 write-only controller.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_SETUP,
    ST_PULSE,
    ST_WAIT,
    ST_IDLE
  } lcd_state_e;

  // One byte transfer to the panel: register select plus data.
  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_byte_t;

  localparam int unsigned INIT_LEN = 6;
  localparam int unsigned IDX_W    = 3;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;

  // Defaults for a 50 MHz clock.
  localparam int unsigned DEF_T_PWRUP = 750000;
  localparam int unsigned DEF_T_SETUP = 3;
  localparam int unsigned DEF_T_EN    = 12;
  localparam int unsigned DEF_T_CMD   = 2000;
  localparam int unsigned DEF_T_CLEAR = 82000;

  function automatic logic [7:0] init_rom(input logic [IDX_W-1:0] idx);
    logic [7:0] val;
    case (idx)
      3'd0, 3'd1, 3'd2: val = CMD_FUNC_SET;
      3'd3:             val = CMD_DISP_ON;
      3'd4:             val = CMD_CLEAR;
      default:          val = CMD_ENTRY;
    endcase
    return val;
  endfunction

  // Clear and home need the long post-pulse wait; character data never does.
  function automatic logic is_slow_cmd(input lcd_byte_t b);
    return !b.rs && ((b.data == CMD_CLEAR) || (b.data == CMD_HOME));
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter; done_c flags the last cycle of a loaded interval.
module lcd_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         done_c,
  output logic         zero_c
);

  logic [W-1:0] cnt_q;

  // Loading N makes done_c rise N-1 cycles later, so an interval spans N cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= value_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done_c = (cnt_q == W'(1));
  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/lcd_controller.sv
// HD44780 8-bit write-only controller: power-up wait, fixed init ROM, then a
// valid/ready byte interface with per-byte setup, enable pulse and settle wait.
module lcd_controller
  import lcd_pkg::*;
#(
  parameter int unsigned T_PWRUP = DEF_T_PWRUP,
  parameter int unsigned T_SETUP = DEF_T_SETUP,
  parameter int unsigned T_EN    = DEF_T_EN,
  parameter int unsigned T_CMD   = DEF_T_CMD,
  parameter int unsigned T_CLEAR = DEF_T_CLEAR
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  input  logic       req_rs_i,
  input  logic [7:0] req_data_i,
  output logic       req_ready_o,
  output logic       init_done_o,
  output logic [7:0] lcd_data_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       lcd_en_o,
  output logic       lcd_on_o
);

  localparam int unsigned T_MAX_A = (T_PWRUP > T_SETUP) ? T_PWRUP : T_SETUP;
  localparam int unsigned T_MAX_B = (T_EN > T_CMD) ? T_EN : T_CMD;
  localparam int unsigned T_MAX_C = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int unsigned T_MAX   = (T_MAX_C > T_CLEAR) ? T_MAX_C : T_CLEAR;
  localparam int unsigned CNT_W   = $clog2(T_MAX) + 1;

  lcd_state_e       state_q, state_d;
  lcd_byte_t        byte_q, byte_d;
  logic             en_q, en_d;
  logic             ready_q, ready_d;
  logic             init_done_q, init_done_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             on_q;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;
  logic             tmr_zero;

  lcd_timer #(.W(CNT_W)) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (tmr_load),
    .value_i (tmr_val),
    .done_c  (tmr_done),
    .zero_c  (tmr_zero)
  );

  // Next-state and next-output logic; the timer is loaded on every state entry.
  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    en_d        = en_q;
    ready_d     = ready_q;
    init_done_d = init_done_q;
    idx_d       = idx_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;

    case (state_q)
      ST_PWRUP: begin
        // Timer is zero only on the first cycle after reset: arm the power-up wait.
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(T_PWRUP - 1);
        end else if (tmr_done) begin
          state_d     = ST_SETUP;
          idx_d       = '0;
          byte_d.rs   = 1'b0;
          byte_d.data = init_rom('0);
          tmr_load    = 1'b1;
          tmr_val     = CNT_W'(T_SETUP);
        end
      end

      ST_SETUP: begin
        if (tmr_done) begin
          state_d  = ST_PULSE;
          en_d     = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(T_EN);
        end
      end

      ST_PULSE: begin
        if (tmr_done) begin
          state_d  = ST_WAIT;
          en_d     = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = is_slow_cmd(byte_q) ? CNT_W'(T_CLEAR) : CNT_W'(T_CMD);
        end
      end

      ST_WAIT: begin
        if (tmr_done) begin
          if (init_done_q || (idx_q == IDX_W'(INIT_LEN - 1))) begin
            state_d     = ST_IDLE;
            ready_d     = 1'b1;
            init_done_d = 1'b1;
          end else begin
            state_d     = ST_SETUP;
            idx_d       = idx_q + IDX_W'(1);
            byte_d.rs   = 1'b0;
            byte_d.data = init_rom(idx_q + IDX_W'(1));
            tmr_load    = 1'b1;
            tmr_val     = CNT_W'(T_SETUP);
          end
        end
      end

      ST_IDLE: begin
        if (req_valid_i && ready_q) begin
          state_d     = ST_SETUP;
          byte_d.rs   = req_rs_i;
          byte_d.data = req_data_i;
          ready_d     = 1'b0;
          tmr_load    = 1'b1;
          tmr_val     = CNT_W'(T_SETUP);
        end
      end

      default: begin
        state_d = ST_PWRUP;
        en_d    = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_PWRUP;
      byte_q      <= '0;
      en_q        <= 1'b0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
      idx_q       <= '0;
      on_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      en_q        <= en_d;
      ready_q     <= ready_d;
      init_done_q <= init_done_d;
      idx_q       <= idx_d;
      on_q        <= 1'b1;
    end
  end

  assign req_ready_o = ready_q;
  assign init_done_o = init_done_q;
  assign lcd_data_o  = byte_q.data;
  assign lcd_rs_o    = byte_q.rs;
  assign lcd_en_o    = en_q;
  assign lcd_on_o    = on_q;
  assign lcd_rw_o    = 1'b0;

endmodule

// File: tb/tb_lcd_controller.sv
// Directed bench for lcd_controller with shortened timing parameters.
module tb_lcd_controller;

  localparam int unsigned TP  = 20;
  localparam int unsigned TS  = 2;
  localparam int unsigned TE  = 3;
  localparam int unsigned TC  = 10;
  localparam int unsigned TCL = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic       rs = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready, init_done, lcd_rs, lcd_rw, lcd_en, lcd_on;
  logic [7:0] lcd_data;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        rs;
    logic [7:0]  data;
    int unsigned wait_len;
  } vec_t;

  vec_t vecs[7];

  lcd_controller #(
    .T_PWRUP(TP), .T_SETUP(TS), .T_EN(TE), .T_CMD(TC), .T_CLEAR(TCL)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (valid),
    .req_rs_i    (rs),
    .req_data_i  (data),
    .req_ready_o (ready),
    .init_done_o (init_done),
    .lcd_data_o  (lcd_data),
    .lcd_rs_o    (lcd_rs),
    .lcd_rw_o    (lcd_rw),
    .lcd_en_o    (lcd_en),
    .lcd_on_o    (lcd_on)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called right after the SETUP-entry edge; walks setup, pulse and wait, ending
  // right after the edge that leaves WAIT.
  task automatic expect_byte(input string name, input logic exp_rs, input logic [7:0] exp_data,
                             input int unsigned wait_len);
    int unsigned en_bad, dat_bad, rdy_bad;
    logic exp_en;
    en_bad = 0; dat_bad = 0; rdy_bad = 0;
    for (int s = 0; s < int'(TS + TE + wait_len); s++) begin
      exp_en = (s >= int'(TS)) && (s < int'(TS + TE));
      if (lcd_en !== exp_en) en_bad++;
      if (lcd_data !== exp_data || lcd_rs !== exp_rs) dat_bad++;
      if (ready !== 1'b0) rdy_bad++;
      tick();
    end
    check($sformatf("%s en_shape", name), en_bad, 0);
    check($sformatf("%s data_stable", name), dat_bad, 0);
    check($sformatf("%s ready_low", name), rdy_bad, 0);
  endtask

  // Called right after a reset edge with rst high; releases reset and checks
  // the power-up wait and the whole init ROM.
  task automatic run_init(input string name);
    int unsigned pw_bad;
    pw_bad = 0;
    rst = 1'b0;
    for (int k = 1; k <= int'(TP); k++) begin
      tick();
      if (k == 1) check($sformatf("%s lcd_on", name), 32'(lcd_on), 1);
      if (lcd_en !== 1'b0 || ready !== 1'b0 || init_done !== 1'b0) pw_bad++;
    end
    check($sformatf("%s pwrup_quiet", name), pw_bad, 0);
    expect_byte($sformatf("%s b0", name), 1'b0, 8'h38, TC);
    expect_byte($sformatf("%s b1", name), 1'b0, 8'h38, TC);
    expect_byte($sformatf("%s b2", name), 1'b0, 8'h38, TC);
    expect_byte($sformatf("%s b3", name), 1'b0, 8'h0C, TC);
    expect_byte($sformatf("%s b4", name), 1'b0, 8'h01, TCL);
    expect_byte($sformatf("%s b5", name), 1'b0, 8'h06, TC);
    check($sformatf("%s init_done", name), 32'(init_done), 1);
    check($sformatf("%s ready", name), 32'(ready), 1);
  endtask

  task automatic send(input string name, input vec_t v);
    check($sformatf("%s ready_before", name), 32'(ready), 1);
    valid = 1'b1; rs = v.rs; data = v.data;
    tick();
    valid = 1'b0; data = 8'hFF; rs = ~v.rs;
    expect_byte(name, v.rs, v.data, v.wait_len);
    check($sformatf("%s ready_after", name), 32'(ready), 1);
  endtask

  initial begin
    vecs[0] = '{rs: 1'b1, data: 8'h41, wait_len: 10};
    vecs[1] = '{rs: 1'b0, data: 8'h01, wait_len: 30};
    vecs[2] = '{rs: 1'b1, data: 8'h01, wait_len: 10};
    vecs[3] = '{rs: 1'b0, data: 8'h02, wait_len: 30};
    vecs[4] = '{rs: 1'b1, data: 8'h02, wait_len: 10};
    vecs[5] = '{rs: 1'b0, data: 8'h0C, wait_len: 10};
    vecs[6] = '{rs: 1'b0, data: 8'h80, wait_len: 10};

    // Reset values
    rst = 1'b1;
    repeat (3) tick();
    check("rst en", 32'(lcd_en), 0);
    check("rst on", 32'(lcd_on), 0);
    check("rst ready", 32'(ready), 0);
    check("rst init_done", 32'(init_done), 0);
    check("rst data", 32'(lcd_data), 0);
    check("rst rs_rw", 32'({lcd_rs, lcd_rw}), 0);

    run_init("init1");

    for (int i = 0; i < 7; i++) send($sformatf("vec%0d", i), vecs[i]);

    // Back-to-back: valid held, second byte taken on the first ready cycle.
    valid = 1'b1; rs = 1'b1; data = 8'h48;
    tick();
    data = 8'h49;
    expect_byte("b2b first", 1'b1, 8'h48, TC);
    check("b2b ready", 32'(ready), 1);
    tick();
    valid = 1'b0;
    expect_byte("b2b second", 1'b1, 8'h49, TC);
    check("b2b ready_after", 32'(ready), 1);

    // Reset during the enable pulse.
    valid = 1'b1; rs = 1'b1; data = 8'h33;
    tick();
    valid = 1'b0;
    repeat (TS) tick();
    check("midpulse en_high", 32'(lcd_en), 1);
    rst = 1'b1;
    tick();
    check("midpulse en_drop", 32'(lcd_en), 0);
    check("midpulse init_done", 32'(init_done), 0);
    check("midpulse ready", 32'(ready), 0);
    check("midpulse on", 32'(lcd_on), 0);

    // Request held through the replayed init is sent unchanged afterwards.
    valid = 1'b1; rs = 1'b1; data = 8'h5A;
    run_init("init2");
    tick();
    valid = 1'b0;
    expect_byte("held", 1'b1, 8'h5A, TC);
    check("held ready_after", 32'(ready), 1);
    check("rw low", 32'(lcd_rw), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_controller.md
LCD_CONTROLLER -- requirements
Module: lcd_controller

Interface
REQ-001 SHALL have parameter T_PWRUP, default 750000, power-up wait in cycles (15 ms at 50 MHz).
REQ-002 SHALL have parameter T_SETUP, default 3, cycles RS/DATA are stable before EN rises.
REQ-003 SHALL have parameter T_EN, default 12, EN high width in cycles (≥230 ns).
REQ-004 SHALL have parameter T_CMD, default 2000, post-pulse wait for normal command/data (40 us).
REQ-005 SHALL have parameter T_CLEAR, default 82000, post-pulse wait for clear/home (1.64 ms).
REQ-006 SHALL have port clk_i, input, 1, the single clock (CLOCK_50 domain).
REQ-007 SHALL have port rst_i, input, 1; reset is synchronous and active-high.
REQ-008 SHALL have port req_valid_i, input, 1, requester has a byte to send.
REQ-009 SHALL have port req_rs_i, input, 1, 0 = command, 1 = character data.
REQ-010 SHALL have port req_data_i, input, 8, byte to send.
REQ-011 SHALL have port req_ready_o, output, 1, controller accepts a request this cycle.
REQ-012 SHALL have port init_done_o, output, 1, init sequence complete.
REQ-013 SHALL have ports lcd_data_o (output, 8), lcd_rs_o, lcd_rw_o, lcd_en_o and lcd_on_o (outputs, 1 each), driving the HD44780 pins.

Function
REQ-014 SHALL implement the states PWRUP, SETUP, PULSE, WAIT and IDLE.
REQ-015 SHALL stay in PWRUP for T_PWRUP cycles after reset, then enter SETUP with init entry 0.
REQ-016 SHALL send the init ROM 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 (RS=0) in order; after the WAIT of entry 5, SHALL set init_done_o=1 and enter IDLE.
REQ-017 SHALL drive, per byte: SETUP with EN=0 for T_SETUP cycles, then PULSE with EN=1 for T_EN cycles, then WAIT with EN=0 for T_CLEAR cycles if RS=0 and data is 0x01 or 0x02, else T_CMD cycles.
REQ-018 SHALL hold lcd_data_o and lcd_rs_o stable from SETUP entry until WAIT exit.
REQ-019 SHALL assert req_ready_o only in IDLE with init_done_o=1; a request is accepted on a clk_i edge where req_valid_i & req_ready_o.
REQ-020 SHALL, on acceptance, latch req_rs_i and req_data_i and enter SETUP on that edge; lcd_* reflect the latched values from the next cycle; req_ready_o deasserts immediately.
REQ-021 SHALL reassert req_ready_o exactly T_SETUP+T_EN+wait cycles after acceptance; back-to-back requests may be accepted on that cycle, and EN pulses SHALL never overlap or be shortened.
REQ-022 SHALL ignore req_valid_i while not ready, with no buffering; the requester holds valid and data until accepted.
REQ-023 SHALL drive lcd_rw_o constant 0 (write-only; busy flag is never read).
REQ-024 SHALL size its counter to $clog2 of the largest timing parameter plus 1, with no wrap during any wait.

Reset
REQ-025 SHALL, while rst_i=1 at a clk_i edge, set state=PWRUP, lcd_en_o=0, lcd_rs_o=0, lcd_data_o=0x00, lcd_rw_o=0, lcd_on_o=0, req_ready_o=0, init_done_o=0, counter=0 and init index=0.
REQ-026 SHALL set lcd_on_o=1 from the first cycle after reset release.
REQ-027 SHALL, when reset is asserted mid-pulse or mid-wait, drop EN on that edge and replay the full power-up and init sequence after release.

Structure
REQ-028 SHALL take the state enum, the init ROM constants (INIT_LEN=6, CMD_CLEAR=0x01, CMD_HOME=0x02) and the default timing constants from a shared package lcd_pkg.
REQ-029 SHALL use one sub-module, lcd_timer: a loadable down-counter with a done flag, reused for every wait.

Verification (bench params T_PWRUP=20, T_SETUP=2, T_EN=3, T_CMD=10, T_CLEAR=30)
REQ-030 Reset release -> ready=0 and EN=0 for 20 cycles; six EN pulses, each 3 cycles wide, carrying 38,38,38,0C,01,06 with RS=0; 30-cycle wait after the 0x01 pulse; init_done_o=1 after the final 10-cycle wait.
REQ-031 Accept RS=1, data 0x41 -> lcd_data_o=0x41 and lcd_rs_o=1 the next cycle; EN high in cycles 3-5 after acceptance; ready reasserts 15 cycles after acceptance.
REQ-032 Command RS=0, data 0x01 -> ready 35 cycles after acceptance; RS=1, data 0x01 -> ready 15 cycles after acceptance (no clear-length wait).
REQ-033 Valid held high with two queued bytes 0x48, 0x49 -> second byte accepted on the exact ready cycle; two distinct 3-cycle EN pulses; data stable across each pulse.
REQ-034 rst_i pulsed during an EN-high cycle -> EN=0 on that edge and init_done_o=0; the full 20-cycle power-up and six-byte init replays.
REQ-035 req_valid_i asserted before init_done_o -> no acceptance until the cycle init_done_o=1; the held byte is then sent unchanged.
